// File: rtl/life_gen_seq.sv
`default_nettype none
// ============================================================================
// Module   : life_gen_seq
// Purpose  : Generation sequencer for the life grid datapath. It drives the
//            shared scan counter across all X*Y cells, fires col_load at every
//            column boundary and commit once per generation. Generations run
//            either single-step or free-run under host control.
// Ports    : clk, reset (async, active-low)
//            step, run, stop, clear, gap   host controls
//            cnt, col_load, commit         datapath controls
//            busy, done, gen_count         host status
// Revision : 1.0 - initial release
// ============================================================================
module life_gen_seq #(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3,
  parameter int GAP_W = 8,
  parameter int GEN_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step,
  input  logic                   run,
  input  logic                   stop,
  input  logic                   clear,
  input  logic [GAP_W-1:0]       gap,
  output logic [LOG2X+LOG2Y-1:0] cnt,
  output logic                   col_load,
  output logic                   commit,
  output logic                   busy,
  output logic                   done,
  output logic [GEN_W-1:0]       gen_count
);

  localparam int            CW   = LOG2X + LOG2Y;
  localparam logic [CW-1:0] LAST = CW'(X * Y - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [GEN_W-1:0] gen_q,   gen_d;
  logic [GAP_W-1:0] gap_q,   gap_d;
  logic             cont_w;

  // Free-run continues only while run is held and stop is not.
  assign cont_w = run & ~stop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gen_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gen_q   <= gen_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gen_d   = gen_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // clear wins over a simultaneous start request
        if (clear) begin
          gen_d = '0;
        end else if ((step | run) & ~stop) begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // counter width is exact, so the last cell wraps cnt back to 0
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        gen_d = gen_q + GEN_W'(1);
        if (cont_w) begin
          if (gap != '0) begin
            state_d = S_GAP;
            gap_d   = gap;
          end else begin
            state_d = S_SCAN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        // gap_q holds the remaining idle cycles including this one
        if (!cont_w) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else if (gap_q <= GAP_W'(1)) begin
          state_d = S_SCAN;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cnt       = cnt_q;
  assign gen_count = gen_q;
  assign col_load  = (state_q == S_SCAN) && (cnt_q[LOG2X-1:0] == '0);
  assign commit    = (state_q == S_COMMIT);
  assign busy      = (state_q != S_IDLE);
  // done marks the final commit of a step or of a stopped free-run
  assign done      = (state_q == S_COMMIT) && !cont_w;

endmodule
`default_nettype wire

// File: tb/tb_life_gen_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_life_gen_seq
// Purpose  : Self-checking directed bench for life_gen_seq (X=Y=8). A second
//            instance with GEN_W=4 shares the stimulus to observe counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_life_gen_seq;

  logic       clk = 1'b0;
  logic       reset, step, run, stop, clear;
  logic [7:0] gap;

  logic [5:0]  cnt, cnt4;
  logic        col_load, commit, busy, done;
  logic        col_load4, commit4, busy4, done4;
  logic [15:0] gen_count;
  logic [3:0]  gen_count4;

  int n_checks = 0;
  int n_err    = 0;

  // cumulative event counters maintained by the monitor only
  int cyc = 0, busy_n = 0, col_n = 0, commit_n = 0, done_n = 0;
  int last_c = 0, space = 0, bad_col = 0, bad_done = 0;

  always #5 clk = ~clk;

  life_gen_seq #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .GAP_W(8), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .step(step), .run(run), .stop(stop), .clear(clear),
    .gap(gap), .cnt(cnt), .col_load(col_load), .commit(commit), .busy(busy),
    .done(done), .gen_count(gen_count)
  );

  life_gen_seq #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .GAP_W(8), .GEN_W(4)) dut4 (
    .clk(clk), .reset(reset), .step(step), .run(run), .stop(stop), .clear(clear),
    .gap(gap), .cnt(cnt4), .col_load(col_load4), .commit(commit4), .busy(busy4),
    .done(done4), .gen_count(gen_count4)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (busy) busy_n = busy_n + 1;
    if (col_load) begin
      col_n = col_n + 1;
      if (cnt[2:0] != 3'd0 || !busy) bad_col = bad_col + 1;
    end
    if (commit) begin
      commit_n = commit_n + 1;
      space    = cyc - last_c;
      last_c   = cyc;
    end
    if (done) begin
      done_n = done_n + 1;
      if (!commit) bad_done = bad_done + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_commits(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (commit_n >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_cnt(input int v, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (busy && cnt == 6'(v)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int c0, d0, b0, l0;
    bit ok;
    reset = 1'b0; step = 1'b0; run = 1'b0; stop = 1'b0; clear = 1'b0; gap = 8'd0;
    repeat (3) tick();
    check("rst_cnt", 32'(cnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_gen", 32'(gen_count), 0);
    check("rst_outs", 32'({col_load, commit, done}), 0);
    reset = 1'b1;
    tick();

    // 1: single step
    c0 = commit_n; d0 = done_n; b0 = busy_n; l0 = col_n;
    pulse_step();
    check("t1_first_cnt", 32'(cnt), 0);
    check("t1_first_col", 32'(col_load), 1);
    wait_idle(200, ok);
    check("t1_in_time", 32'(ok), 1);
    check("t1_busy_cycles", 32'(busy_n - b0), 65);
    check("t1_col_loads", 32'(col_n - l0), 8);
    check("t1_commits", 32'(commit_n - c0), 1);
    check("t1_dones", 32'(done_n - d0), 1);
    check("t1_gen", 32'(gen_count), 1);
    check("t1_cnt_idle", 32'(cnt), 0);

    // 2: free-run with gap=4, then gap=0
    gap = 8'd4; run = 1'b1;
    c0 = commit_n; d0 = done_n;
    wait_commits(c0 + 3, 400, ok);
    check("t2_in_time", 32'(ok), 1);
    run = 1'b0;
    tick();
    check("t2_idle_from_gap", 32'(busy), 0);
    check("t2_gen", 32'(gen_count), 4);
    check("t2_spacing_gap4", 32'(space), 69);
    check("t2_no_done", 32'(done_n - d0), 0);
    gap = 8'd0; run = 1'b1;
    c0 = commit_n; d0 = done_n;
    wait_commits(c0 + 1, 200, ok);
    check("t2b_in_time", 32'(ok), 1);
    run = 1'b0;
    wait_idle(200, ok);
    check("t2b_idle", 32'(ok), 1);
    check("t2b_spacing_gap0", 32'(space), 65);
    check("t2b_gen", 32'(gen_count), 6);
    check("t2b_done", 32'(done_n - d0), 1);

    // 3: stop mid-scan finishes the generation
    gap = 8'd4; c0 = commit_n; d0 = done_n;
    run = 1'b1;
    wait_cnt(20, 100, ok);
    check("t3_reach_20", 32'(ok), 1);
    stop = 1'b1;
    wait_idle(200, ok);
    check("t3_idle", 32'(ok), 1);
    check("t3_gen", 32'(gen_count), 7);
    check("t3_commits", 32'(commit_n - c0), 1);
    check("t3_done", 32'(done_n - d0), 1);
    repeat (3) tick();
    check("t3_stays_idle", 32'(busy), 0);
    run = 1'b0; stop = 1'b0;

    // 4: async reset mid-scan
    pulse_step();
    wait_cnt(30, 100, ok);
    check("t4_reach_30", 32'(ok), 1);
    #2 reset = 1'b0;
    #1;
    check("t4_cnt", 32'(cnt), 0);
    check("t4_busy", 32'(busy), 0);
    check("t4_col", 32'(col_load), 0);
    check("t4_gen", 32'(gen_count), 0);
    tick();
    reset = 1'b1;
    repeat (5) tick();
    check("t4_idle_after", 32'(busy), 0);
    check("t4_cnt_after", 32'(cnt), 0);

    // 5: 16 steps, wrap in the GEN_W=4 instance, clear while busy ignored
    for (int i = 0; i < 16; i++) begin
      pulse_step();
      if (i == 0) begin
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
      end
      wait_idle(200, ok);
      check("t5_step_idle", 32'(ok), 1);
      if (i == 0)  check("t5_clear_busy_ignored", 32'(gen_count), 1);
      if (i == 14) check("t5_gen4_15", 32'(gen_count4), 15);
    end
    check("t5_gen4_wrap", 32'(gen_count4), 0);
    check("t5_gen16", 32'(gen_count), 16);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5_clear_idle", 32'(gen_count), 0);

    // 6: step+clear together, then step while busy dropped
    pulse_step();
    wait_idle(200, ok);
    check("t6_pre_gen", 32'(gen_count), 1);
    step = 1'b1; clear = 1'b1;
    tick();
    step = 1'b0; clear = 1'b0;
    check("t6_clear_gen", 32'(gen_count), 0);
    check("t6_no_scan", 32'(busy), 0);
    c0 = commit_n;
    pulse_step();
    repeat (10) tick();
    pulse_step();
    wait_idle(200, ok);
    check("t6_idle", 32'(ok), 1);
    check("t6_single_commit", 32'(commit_n - c0), 1);
    check("t6_gen", 32'(gen_count), 1);
    repeat (3) tick();
    check("t6_no_queue", 32'(busy), 0);

    check("mon_col_align", 32'(bad_col), 0);
    check("mon_done_with_commit", 32'(bad_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
